uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame (5..8).
REQ-002 Parameter SB_TICK, default 16, oversampling ticks in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 s_tick  input  1  16x-baud enable pulse, one clk wide, driven by the baud-rate tick generator's max_tick.
REQ-006 tx_start  input  1  request to send the byte on din; sampled only in IDLE.
REQ-007 din  input  DBIT  data byte to transmit.
REQ-008 tx  output  1  serial line, registered, idle high.
REQ-009 tx_busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 tx_done_tick  output  1  one-clk pulse at frame completion.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY SHALL exist only as defined in REQ-025.
REQ-012 Internal registers SHALL be: tick counter s_cnt (4 bits, wider if SB_TICK > 16), bit counter n_cnt (3 bits), shift register b_reg (DBIT bits), registered tx.
REQ-013 IDLE: tx = 1; when tx_start = 1, the FSM SHALL latch din into b_reg, clear s_cnt, and enter START on the same edge.
REQ-014 tx_start in any state other than IDLE SHALL be ignored, with no queuing and no effect on the frame in progress.
REQ-015 s_cnt SHALL advance only on clocks where s_tick = 1; clocks without s_tick SHALL hold all counters.
REQ-016 START: tx = 0; at s_tick with s_cnt = 15, the FSM SHALL clear s_cnt and n_cnt and enter DATA.
REQ-017 DATA: tx = b_reg[0], sent LSB first; at s_tick with s_cnt = 15, b_reg SHALL shift right by one and s_cnt SHALL clear.
REQ-018 DATA exit: when n_cnt = DBIT-1 at that same boundary, the FSM SHALL enter PARITY, or STOP if parity is not compiled in; otherwise n_cnt SHALL increment.
REQ-019 STOP: tx = 1; at s_tick with s_cnt = SB_TICK-1, the FSM SHALL assert tx_done_tick for exactly one clk and return to IDLE.
REQ-020 Frame length SHALL be exactly 16*(1+DBIT+P) + SB_TICK s_ticks, where P = 1 with parity and 0 without.
REQ-021 tx SHALL change only on clk edges and SHALL never glitch.
REQ-022 The tx level for each state SHALL be registered, so tx takes the state's level one clk after the state is entered.
REQ-023 tx_start asserted in the same cycle as tx_done_tick SHALL be ignored.
REQ-024 tx_start asserted on the following clock (IDLE) SHALL start a new frame, giving back-to-back frames with no idle gap beyond one clk.

Configuration
REQ-025 Macro UART_TX_PARITY_EN: when defined, PARITY SHALL transmit the even-parity bit (XOR of all DBIT data bits, computed at latch time) for 16 s_ticks between DATA and STOP; when undefined, PARITY and its logic SHALL be absent and DATA SHALL go directly to STOP.

Reset
REQ-026 While reset = 1, and on reset assertion, the block SHALL set: state = IDLE, tx = 1, tx_busy = 0, tx_done_tick = 0, s_cnt = 0, n_cnt = 0, b_reg = 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, force tx high, and produce no tx_done_tick.
REQ-028 The first tx_start after reset release SHALL be honoured.

Verification
REQ-029 Byte send, no parity: s_tick every 4th clk, din = 8'hA5, tx_start pulsed once -> tx bits 0,1,0,1,0,0,1,0,1,1, each held 64 clks; one tx_done_tick pulse; tx_busy high for 640 clks.
REQ-030 Busy-ignore: tx_start with din = 8'h3C, then tx_start with din = 8'hFF during DATA -> only 8'h3C serialized; exactly one tx_done_tick.
REQ-031 Back-to-back: din = 8'h01, then tx_start one clk after tx_done_tick with din = 8'h80 -> two complete frames separated by at most one clk of idle high.
REQ-032 Reset abort: assert reset at bit 4 of a frame -> tx = 1 within the reset assertion; no tx_done_tick; a next frame with 8'h55 is sent correctly.
REQ-033 Parity (UART_TX_PARITY_EN defined): din = 8'h07 -> parity bit 1; din = 8'h03 -> parity bit 0; each frame 176 s_ticks long.
REQ-034 Stop length: SB_TICK = 32, din = 8'h00 -> stop bit held for 32 s_ticks, total frame 176 s_ticks.

Source files
------------

// File: rtl/uart_tx_if.sv
// UART transmitter port bundle: baud tick, start request and data in; serial line and status out.
// Latency: none, wires only.
// Backpressure: tx_busy high means tx_start is ignored; there is no queuing.
interface uart_tx_if #(
    parameter int DBIT = 8
);
    logic            s_tick;
    logic            tx_start;
    logic [DBIT-1:0] din;
    logic            tx;
    logic            tx_busy;
    logic            tx_done_tick;

    // Driver side: the tick generator and the byte source.
    modport master (
        output s_tick, tx_start, din,
        input  tx, tx_busy, tx_done_tick
    );

    // Transmitter side.
    modport slave (
        input  s_tick, tx_start, din,
        output tx, tx_busy, tx_done_tick
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional even parity, SB_TICK/16 stop bits.
// Latency: tx follows the FSM state by one clk; a frame lasts 16*(1+DBIT+P)+SB_TICK s_ticks.
// Backpressure: tx_start is only sampled in IDLE (tx_busy low). Macro UART_TX_PARITY_EN adds the parity bit.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave u
);

    // Tick counter must hold SB_TICK-1 during the stop bit, and 15 during every other bit.
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam logic [SW-1:0] BIT_LAST  = SW'(15);
    localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic [2:0]      n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] b_reg_q, b_reg_d;
    logic            tx_q, tx_d;
    logic            done_tick;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    // State and datapath registers; reset aborts any frame and parks the line high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            b_reg_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            b_reg_q <= b_reg_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic; tx_d is the current state's line level, so tx lags the state by one clk.
    always_comb begin
        state_d   = state_q;
        s_cnt_d   = s_cnt_q;
        n_cnt_d   = n_cnt_q;
        b_reg_d   = b_reg_q;
        tx_d      = 1'b1;
        done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (u.tx_start) begin
                    state_d = START;
                    s_cnt_d = '0;
                    b_reg_d = u.din;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^u.din;
`endif
                end
            end
            START: begin
                tx_d = 1'b0;
                if (u.s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        state_d = DATA;
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            DATA: begin
                tx_d = b_reg_q[0];
                if (u.s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        s_cnt_d = '0;
                        b_reg_d = b_reg_q >> 1;
                        if (n_cnt_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_cnt_d = n_cnt_q + 3'd1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = par_q;
                if (u.s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                        s_cnt_d = '0;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (u.s_tick) begin
                    if (s_cnt_q == STOP_LAST) begin
                        state_d   = IDLE;
                        done_tick = 1'b1;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign u.tx           = tx_q;
    assign u.tx_busy      = (state_q != IDLE);
    assign u.tx_done_tick = done_tick;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int DBIT = 8;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int SB0    = 16;
    localparam int SB1    = 32;
    localparam int TICKS0 = 16 * (1 + DBIT + P) + SB0;
    localparam int TICKS1 = 16 * (1 + DBIT + P) + SB1;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       s_tick = 1'b0;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] din0   = 8'h00;
    logic [7:0] din1   = 8'h00;

    uart_tx_if #(.DBIT(DBIT)) u0 ();
    uart_tx_if #(.DBIT(DBIT)) u1 ();

    assign u0.s_tick   = s_tick;
    assign u0.tx_start = start0;
    assign u0.din      = din0;
    assign u1.s_tick   = s_tick;
    assign u1.tx_start = start1;
    assign u1.din      = din1;

    uart_tx #(.DBIT(DBIT), .SB_TICK(SB0)) dut0 (.clk(clk), .reset(reset), .u(u0.slave));
    uart_tx #(.DBIT(DBIT), .SB_TICK(SB1)) dut1 (.clk(clk), .reset(reset), .u(u1.slave));

    always #5 clk = ~clk;

    // s_tick: one clk high out of every four.
    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 s_tick = 1'b1;
            @(posedge clk);
            #1 s_tick = 1'b0;
        end
    end

    typedef struct {
        logic [7:0] data;
        int         ticks;
        int         busy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    int          tcnt[2];
    int          busy_n[2];
    int          stop_bad[2];
    logic [15:0] bits[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic clear_mon(input int id);
        tcnt[id]     = 0;
        busy_n[id]   = 0;
        stop_bad[id] = 0;
        bits[id]     = '1;
    endtask

    // Monitor: decodes the serial line at mid-bit tick positions and scores each frame on tx_done_tick.
    task automatic mon(input int id, input logic tx, input logic busy, input logic done);
        exp_t e;
        bit   have;
        if (reset) begin
            chk("reset_tx_high", tx, 1);
            chk("reset_busy_low", busy, 0);
            chk("reset_done_low", done, 0);
            clear_mon(id);
            return;
        end
        if (!busy) chk("idle_tx_high", tx, 1);
        if (busy) begin
            busy_n[id]++;
            if (s_tick) begin
                tcnt[id]++;
                if (tcnt[id] % 16 == 8 && tcnt[id] / 16 < 16) bits[id][tcnt[id] / 16] = tx;
                if (tcnt[id] > 16 * (1 + DBIT + P) && tx !== 1'b1) stop_bad[id]++;
            end
        end
        if (done) begin
            have = 1'b0;
            if (id == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (id == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (!have) begin
                chk("unexpected_done", 1, 0);
            end else begin
                chk("start_bit", bits[id][0], 0);
                chk("data_byte", bits[id][8:1], e.data);
`ifdef UART_TX_PARITY_EN
                chk("parity_bit", bits[id][9], ^e.data);
`endif
                chk("stop_bit", bits[id][1 + DBIT + P], 1);
                chk("frame_ticks", tcnt[id], e.ticks);
                chk("stop_held_high", stop_bad[id], 0);
                if (e.busy > 0) chk("busy_clks", busy_n[id], e.busy);
            end
            clear_mon(id);
        end
    endtask

    always @(negedge clk) mon(0, u0.tx, u0.tx_busy, u0.tx_done_tick);
    always @(negedge clk) mon(1, u1.tx, u1.tx_busy, u1.tx_done_tick);

    task automatic push(input int id, input logic [7:0] d, input int ticks, input int busy);
        exp_t e;
        e.data  = d;
        e.ticks = ticks;
        e.busy  = busy;
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    // Issue tx_start in a cycle where s_tick is high, so the first frame tick lands 4 clks later.
    task automatic send(input int id, input logic [7:0] d, input bit record);
        int n;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!s_tick && n < 10);
        if (id == 0) begin start0 = 1'b1; din0 = d; end
        else         begin start1 = 1'b1; din1 = d; end
        if (record) begin
            if (id == 0) push(0, d, TICKS0, 4 * TICKS0);
            else         push(1, d, TICKS1, 4 * TICKS1);
        end
        @(posedge clk); #2;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_idle(input int id);
        int n;
        n = 0;
        while ((id == 0 ? u0.tx_busy : u1.tx_busy) && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 3000) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_done0();
        int n;
        n = 0;
        while (!u0.tx_done_tick && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 3000) chk("done_timeout", 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_mon(0);
        clear_mon(1);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (5) @(posedge clk);
        #2;

        // First start after reset, 0xA5 -> 0,1,0,1,0,0,1,0,1,1.
        send(0, 8'hA5, 1);
        wait_idle(0);

        // Second request during DATA must be ignored.
        send(0, 8'h3C, 1);
        repeat (64 * 3) @(posedge clk);
        #2 start0 = 1'b1; din0 = 8'hFF;
        @(posedge clk);
        #2 start0 = 1'b0;
        wait_idle(0);

        // Back-to-back: request in the done cycle is ignored, the one a clk later starts 0x80.
        send(0, 8'h01, 1);
        wait_done0();
        start0 = 1'b1; din0 = 8'hFF;
        @(posedge clk);
        #2 din0 = 8'h80;
        push(0, 8'h80, TICKS0, 4 * TICKS0 - 1);
        @(posedge clk);
        #2 start0 = 1'b0;
        wait_idle(0);

        // Reset in the middle of data bit 4 aborts the frame with no done pulse.
        send(0, 8'hC3, 0);
        repeat (64 * 5 + 32) @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("abort_tx_high", u0.tx, 1);
        chk("abort_busy_low", u0.tx_busy, 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        send(0, 8'h55, 1);
        wait_idle(0);

        // Parity patterns (odd and even popcount).
        send(0, 8'h07, 1);
        wait_idle(0);
        send(0, 8'h03, 1);
        wait_idle(0);

        // Two stop bits on the second instance.
        send(1, 8'h00, 1);
        wait_idle(1);

        repeat (20) @(posedge clk);
        #2;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
